// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg: shared FSM state type and parameter legality check for the byte packer.
package fifo_packer_pkg;

    typedef enum logic [1:0] {
        S_PACK,
        S_FLUSH_WAIT,
        S_FLUSH_EMIT
    } state_t;

    function automatic bit ratio_ok(int r);
        return r >= 2 && (r & (r - 1)) == 0;
    endfunction

endpackage

// File: rtl/fifo_packer_out_stage.sv
// fifo_packer_out_stage: single-entry valid/ready holding register for packed words.
module fifo_packer_out_stage #(
    parameter int DATA_BITS = 32,
    parameter int KEEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic [KEEP_BITS-1:0] load_keep,
    input  logic                 load_last,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic [KEEP_BITS-1:0] m_keep,
    output logic                 m_last
);

    // load is only raised while the slot is free, so a held word never changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: packs FIFO read-side entries into wide words, with flush emitting a
// partial word carrying lane-keep bits and a last marker.
module fifo_byte_packer
    import fifo_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic                             fifo_valid,
    input  logic [DATA_WIDTH-1:0]            fifo_dout,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep,
    output logic                             m_last,
    output logic                             overflow_err
);

    localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
    localparam int CW = $clog2(PACK_RATIO) + 1;

    if (!ratio_ok(PACK_RATIO)) begin : g_bad_ratio
        $error("PACK_RATIO must be a power of two >= 2");
    end

    state_t state;
    logic [CW-1:0] byte_cnt;
    logic inflight;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes;
    logic full, slot_free, load, capture;
    logic [OUT_WIDTH-1:0] load_data;
    logic [PACK_RATIO-1:0] load_keep;

    assign full = byte_cnt == CW'(PACK_RATIO);
    assign slot_free = !m_valid || m_ready;
    assign load = slot_free && (full || (state == S_FLUSH_EMIT && byte_cnt != '0));
    assign capture = fifo_valid && !full;
    assign fifo_rd_en = rst_n && state == S_PACK && !fifo_empty && !flush &&
                        ((CW + 1)'(byte_cnt) + (CW + 1)'(inflight) < (CW + 1)'(PACK_RATIO));

    // lanes beyond byte_cnt are zeroed so a partial word carries no stale data
    for (genvar k = 0; k < PACK_RATIO; k++) begin : g_lane
        assign load_keep[k] = CW'(k) < byte_cnt;
        assign load_data[k*DATA_WIDTH +: DATA_WIDTH] = load_keep[k] ? lanes[k] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_PACK;
            byte_cnt     <= '0;
            inflight     <= 1'b0;
            lanes        <= '0;
            overflow_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) lanes[byte_cnt[CW-2:0]] <= fifo_dout;
            if (fifo_valid && full) overflow_err <= 1'b1;
            byte_cnt <= load ? '0 : byte_cnt + CW'(capture);
            state <= state == S_PACK       ? (flush ? S_FLUSH_WAIT : S_PACK)
                   : state == S_FLUSH_WAIT ? (inflight ? S_FLUSH_WAIT : S_FLUSH_EMIT)
                   : (byte_cnt == '0 || slot_free) ? S_PACK : S_FLUSH_EMIT;
        end
    end

    fifo_packer_out_stage #(
        .DATA_BITS(OUT_WIDTH),
        .KEEP_BITS(PACK_RATIO)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .load_keep(load_keep),
        .load_last(!full),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer: directed bench with a FIFO model and a byte-grouping scoreboard.
module tb_fifo_byte_packer;

    localparam int PR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fifo_empty = 1'b1;
    logic fifo_valid = 1'b0;
    logic [7:0] fifo_dout = '0;
    logic flush = 1'b0;
    logic m_ready = 1'b1;
    logic fifo_rd_en, m_valid, m_last, overflow_err;
    logic [31:0] m_data;
    logic [3:0] m_keep;

    always #5 clk = ~clk;

    fifo_byte_packer #(.DATA_WIDTH(8), .PACK_RATIO(PR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_valid  (fifo_valid),
        .fifo_dout   (fifo_dout),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .overflow_err(overflow_err)
    );

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];
    int got_cyc[$];
    logic [7:0] fq[$];
    logic [7:0] cur[$];
    int total = 0;
    int bad = 0;
    int pops = 0;
    int cyc = 0;
    bit inject = 0;
    logic [7:0] inj_byte = '0;
    bit prev_hold = 0;
    word_t prev;
    word_t cmp_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Bytes group in read order; a flush closes whatever group is open.
    function automatic word_t pack_cur();
        word_t w;
        w = '0;
        foreach (cur[i]) w.data[i*8 +: 8] = cur[i];
        w.keep = 4'((1 << cur.size()) - 1);
        w.last = cur.size() < PR;
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold)
                check("hold_stable", {m_valid, m_last, m_keep, m_data},
                      {1'b1, prev.last, prev.keep, prev.data});
            if (m_valid && m_ready) begin
                got_q.push_back({m_last, m_keep, m_data});
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {m_last, m_keep, m_data}, 64'hDEAD_0000_0000_0000);
                end else begin
                    cmp_w = exp_q.pop_front();
                    check("word", {m_last, m_keep, m_data}, cmp_w);
                end
            end
            prev_hold = m_valid && !m_ready;
            prev = {m_last, m_keep, m_data};
        end else begin
            prev_hold = 0;
        end
    end

    task automatic step();
        bit pop;
        @(negedge clk);
        pop = rst_n && fifo_rd_en && fq.size() > 0;
        if (rst_n && flush && cur.size() > 0) begin
            exp_q.push_back(pack_cur());
            cur.delete();
        end
        @(posedge clk);
        #1;
        fifo_valid = 1'b0;
        if (pop) begin
            fifo_valid = 1'b1;
            fifo_dout = fq.pop_front();
            pops++;
            cur.push_back(fifo_dout);
            if (cur.size() == PR) begin
                exp_q.push_back(pack_cur());
                cur.delete();
            end
        end else if (inject) begin
            fifo_valid = 1'b1;
            fifo_dout = inj_byte;
            inject = 0;
        end
        fifo_empty = fq.size() == 0;
    endtask

    task automatic push_seq(logic [7:0] first, int n);
        for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
        fifo_empty = 1'b0;
    endtask

    task automatic wait_words(string name, int n, int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, got_q.size(), n);
    endtask

    task automatic expect_got(string name, int idx, word_t w);
        if (idx < got_q.size()) check(name, got_q[idx], w);
        else check(name, 64'hFFFF_FFFF_FFFF_FFFF, w);
    endtask

    task automatic reset_and_check(string name);
        rst_n = 1'b0;
        fq.delete();
        cur.delete();
        exp_q.delete();
        fifo_valid = 1'b0;
        fifo_empty = 1'b1;
        inject = 0;
        @(negedge clk);
        check(name, {m_valid, m_last, m_keep, m_data, overflow_err, fifo_rd_en}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        int k, vs, p0;
        #2;
        reset_and_check("reset_state");
        repeat (2) step();

        // two full words
        push_seq(8'h01, 8);
        wait_words("full_count", 2, 100);
        expect_got("full_w0", 0, {1'b0, 4'hF, 32'h04030201});
        expect_got("full_w1", 1, {1'b0, 4'hF, 32'h08070605});
        repeat (5) step();
        check("full_no_extra", got_q.size(), 2);

        // sustained throughput with a never-empty FIFO
        got_q.delete();
        got_cyc.delete();
        push_seq(8'h21, 12);
        wait_words("tput_count", 3, 100);
        if (got_cyc.size() >= 3) begin
            check("tput_gap01", got_cyc[1] - got_cyc[0], 6);
            check("tput_gap12", got_cyc[2] - got_cyc[1], 6);
        end
        repeat (5) step();

        // backpressure
        got_q.delete();
        m_ready = 1'b0;
        p0 = pops;
        push_seq(8'h01, 12);
        repeat (40) step();
        check("bp_reads", pops - p0, 8);
        check("bp_no_words", got_q.size(), 0);
        m_ready = 1'b1;
        wait_words("bp_count", 3, 100);
        expect_got("bp_w0", 0, {1'b0, 4'hF, 32'h04030201});
        expect_got("bp_w1", 1, {1'b0, 4'hF, 32'h08070605});
        expect_got("bp_w2", 2, {1'b0, 4'hF, 32'h0C0B0A09});
        repeat (5) step();

        // partial flush
        got_q.delete();
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        fq.push_back(8'hCC);
        fifo_empty = 1'b0;
        repeat (8) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        k = 0;
        while (!m_valid && k < 20) begin
            step();
            k++;
        end
        check("flush_latency", k + 1, 3);
        wait_words("flush_count", 1, 20);
        expect_got("flush_w", 0, {1'b1, 4'h7, 32'h00CCBBAA});
        repeat (5) step();

        // flush with empty assembly
        got_q.delete();
        flush = 1'b1;
        step();
        flush = 1'b0;
        vs = 0;
        repeat (10) begin
            step();
            if (m_valid) vs++;
        end
        check("empty_flush_valid", vs, 0);

        // flush while the fourth byte is in flight
        got_q.delete();
        p0 = pops;
        push_seq(8'h41, 4);
        k = 0;
        while (pops < p0 + 4 && k < 50) begin
            step();
            k++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words("inflight_count", 1, 20);
        expect_got("inflight_w", 0, {1'b0, 4'hF, 32'h44434241});
        repeat (10) step();
        check("inflight_no_extra", got_q.size(), 1);

        // unsolicited byte with the assembly full
        got_q.delete();
        m_ready = 1'b0;
        push_seq(8'h51, 8);
        repeat (20) step();
        check("ovf_clear", overflow_err, 0);
        inj_byte = 8'hEE;
        inject = 1;
        repeat (3) step();
        check("ovf_set", overflow_err, 1);
        m_ready = 1'b1;
        wait_words("ovf_count", 2, 50);
        expect_got("ovf_w0", 0, {1'b0, 4'hF, 32'h54535251});
        expect_got("ovf_w1", 1, {1'b0, 4'hF, 32'h58575655});
        repeat (5) step();
        check("ovf_sticky", overflow_err, 1);
        check("ovf_no_extra", got_q.size(), 2);

        // reset in the middle of a word
        fq.push_back(8'h61);
        fq.push_back(8'h62);
        fifo_empty = 1'b0;
        repeat (6) step();
        reset_and_check("midword_reset");
        push_seq(8'h11, 4);
        wait_words("midword_count", 1, 50);
        expect_got("midword_w", 0, {1'b0, 4'hF, 32'h14131211});
        repeat (10) step();
        check("midword_no_extra", got_q.size(), 1);
        check("exp_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
